pwr_rail_monitor: RTL and testbench

Supervises the power rails driven by the power-up/power-down step enables and checks each rail's power-good (PG) feedback against its enable. Each rail must follow its enable within a timeout and must not drop out while on. On any violation the block latches a fault record and raises a power-off request, which feeds the sequencer's `en_pwr_off` input. It sits between the init/power sequencer and the board PG pins, in the `fsm_clk` domain.

---
 rtl/pwr_rail_monitor.sv | 196 +++++++++++++++++++
 tb/tb_pwr_rail_monitor.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_rail_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pwr_rail_monitor
// Purpose  : PG supervision of sequenced rails with latched fault record
// Revision : 1.0 - initial release
// ============================================================================
module pwr_rail_monitor #(
    parameter int NUM_RAILS  = 6,
    parameter int PG_TIMEOUT = 2000,
    parameter int DEGLITCH   = 4,
    parameter int CNT_W      = 25
) (
    input  logic                 fsm_clk,
    input  logic                 reset_n,
    input  logic [NUM_RAILS-1:0] rail_en,
    input  logic [NUM_RAILS-1:0] pg_in,
    input  logic                 fault_clr,
    output logic [NUM_RAILS-1:0] pg_db,
    output logic                 all_pg,
    output logic                 pwr_fault,
    output logic [NUM_RAILS-1:0] fault_rail,
    output logic [1:0]           fault_code,
    output logic                 req_pwr_off
);

    localparam int c_DG_W = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;

    localparam logic [1:0] c_CODE_NONE  = 2'b00;
    localparam logic [1:0] c_CODE_RISE  = 2'b01;
    localparam logic [1:0] c_CODE_DROP  = 2'b10;
    localparam logic [1:0] c_CODE_STUCK = 2'b11;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RAMP_UP = 3'd1,
        S_ON      = 3'd2,
        S_RAMP_DN = 3'd3,
        S_FAULT   = 3'd4
    } rail_state_t;

    logic [NUM_RAILS-1:0] r_sync1;
    logic [NUM_RAILS-1:0] r_sync2;
    logic [NUM_RAILS-1:0] w_in_on;
    logic [NUM_RAILS-1:0] w_in_fault;
    logic [NUM_RAILS-1:0] w_enter_fault;
    logic [1:0]           w_code [NUM_RAILS];
    logic [1:0]           w_first_code;

    logic                 r_all_pg;
    logic                 r_pwr_fault;
    logic [NUM_RAILS-1:0] r_fault_rail;
    logic [1:0]           r_fault_code;
    logic                 r_req_pwr_off;

    always_ff @(posedge fsm_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pg_in;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RAILS; gi++) begin : g_rail
            logic [c_DG_W-1:0] r_dg_cnt;
            logic              r_db;
            rail_state_t       r_state;
            rail_state_t       w_state_nxt;
            logic [CNT_W-1:0]  r_timer;
            logic              w_timeout;
            logic [1:0]        w_code_nxt;

            always_ff @(posedge fsm_clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_dg_cnt <= '0;
                    r_db     <= 1'b0;
                end else if (r_sync2[gi] == r_db) begin
                    r_dg_cnt <= '0;
                end else if (r_dg_cnt == c_DG_W'(DEGLITCH - 1)) begin
                    r_db     <= r_sync2[gi];
                    r_dg_cnt <= '0;
                end else begin
                    r_dg_cnt <= r_dg_cnt + c_DG_W'(1);
                end
            end

            assign w_timeout = (r_timer == CNT_W'(PG_TIMEOUT - 1));

            // PG acceptance is checked before enable and timeout in both ramps
            always_comb begin
                w_state_nxt = r_state;
                w_code_nxt  = c_CODE_NONE;
                case (r_state)
                    S_OFF: begin
                        if (rail_en[gi]) w_state_nxt = S_RAMP_UP;
                    end
                    S_RAMP_UP: begin
                        if (r_db) begin
                            w_state_nxt = S_ON;
                        end else if (!rail_en[gi]) begin
                            w_state_nxt = S_RAMP_DN;
                        end else if (w_timeout) begin
                            w_state_nxt = S_FAULT;
                            w_code_nxt  = c_CODE_RISE;
                        end
                    end
                    S_ON: begin
                        if (!rail_en[gi]) begin
                            w_state_nxt = S_RAMP_DN;
                        end else if (!r_db) begin
                            w_state_nxt = S_FAULT;
                            w_code_nxt  = c_CODE_DROP;
                        end
                    end
                    S_RAMP_DN: begin
                        if (!r_db) begin
                            w_state_nxt = S_OFF;
                        end else if (rail_en[gi]) begin
                            w_state_nxt = S_RAMP_UP;
                        end else if (w_timeout) begin
                            w_state_nxt = S_FAULT;
                            w_code_nxt  = c_CODE_STUCK;
                        end
                    end
                    S_FAULT: begin
                        if (fault_clr && !rail_en[gi]) w_state_nxt = S_OFF;
                    end
                    default: w_state_nxt = S_OFF;
                endcase
            end

            always_ff @(posedge fsm_clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= S_OFF;
                    r_timer <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    if (w_state_nxt != r_state) begin
                        r_timer <= '0;
                    end else if (r_state == S_RAMP_UP || r_state == S_RAMP_DN) begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
            end

            assign pg_db[gi]         = r_db;
            assign w_in_on[gi]       = (r_state == S_ON);
            assign w_in_fault[gi]    = (r_state == S_FAULT);
            assign w_enter_fault[gi] = (w_state_nxt == S_FAULT) && (r_state != S_FAULT);
            assign w_code[gi]        = w_code_nxt;
        end
    endgenerate

    // Lowest-indexed newly faulting rail supplies the recorded code
    always_comb begin
        w_first_code = c_CODE_NONE;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (w_enter_fault[i]) w_first_code = w_code[i];
        end
    end

    always_ff @(posedge fsm_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_all_pg      <= 1'b0;
            r_pwr_fault   <= 1'b0;
            r_fault_rail  <= '0;
            r_fault_code  <= c_CODE_NONE;
            r_req_pwr_off <= 1'b0;
        end else begin
            r_all_pg    <= &w_in_on;
            r_pwr_fault <= |w_in_fault;
            if (!(|w_in_fault)) begin
                if (|w_enter_fault) begin
                    r_fault_rail  <= w_enter_fault;
                    r_fault_code  <= w_first_code;
                    r_req_pwr_off <= 1'b1;
                end else begin
                    r_fault_rail  <= '0;
                    r_fault_code  <= c_CODE_NONE;
                    r_req_pwr_off <= 1'b0;
                end
            end
        end
    end

    assign all_pg      = r_all_pg;
    assign pwr_fault   = r_pwr_fault;
    assign fault_rail  = r_fault_rail;
    assign fault_code  = r_fault_code;
    assign req_pwr_off = r_req_pwr_off;

endmodule
`default_nettype wire

// File: tb/tb_pwr_rail_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwr_rail_monitor
// Purpose  : Directed and randomized checks of pwr_rail_monitor vs a rule model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwr_rail_monitor;

    localparam int NR = 6;
    localparam int PT = 16;
    localparam int DG = 4;
    localparam int CW = 5;

    logic          fsm_clk   = 1'b0;
    logic          reset_n   = 1'b0;
    logic [NR-1:0] rail_en   = '0;
    logic [NR-1:0] pg_in     = '0;
    logic          fault_clr = 1'b0;
    logic [NR-1:0] pg_db;
    logic          all_pg;
    logic          pwr_fault;
    logic [NR-1:0] fault_rail;
    logic [1:0]    fault_code;
    logic          req_pwr_off;

    int n_checks = 0;
    int n_fail   = 0;

    pwr_rail_monitor #(
        .NUM_RAILS  (NR),
        .PG_TIMEOUT (PT),
        .DEGLITCH   (DG),
        .CNT_W      (CW)
    ) dut (
        .fsm_clk     (fsm_clk),
        .reset_n     (reset_n),
        .rail_en     (rail_en),
        .pg_in       (pg_in),
        .fault_clr   (fault_clr),
        .pg_db       (pg_db),
        .all_pg      (all_pg),
        .pwr_fault   (pwr_fault),
        .fault_rail  (fault_rail),
        .fault_code  (fault_code),
        .req_pwr_off (req_pwr_off)
    );

    always #5 fsm_clk = ~fsm_clk;

    // Reference model: rail states with entry-cycle stamps, PG history window
    typedef enum int {R_OFF, R_UP, R_ON, R_DN, R_FLT} rail_t;
    rail_t         m_st    [NR];
    rail_t         m_nx    [NR];
    int            m_entry [NR];
    int            m_code  [NR];
    logic [15:0]   m_hist  [NR];
    int            cyc;
    logic          m_any_flt;
    logic          m_all_on;
    logic          m_flip;
    logic [NR-1:0] m_enter;
    logic [NR-1:0] e_pg_db;
    logic [NR-1:0] e_fault_rail;
    logic          e_all_pg;
    logic          e_pwr_fault;
    logic          e_req;
    logic [1:0]    e_code;

    always @(posedge fsm_clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0;
            for (int i = 0; i < NR; i++) begin
                m_st[i]    = R_OFF;
                m_entry[i] = 0;
                m_hist[i]  = '0;
            end
            e_pg_db      = '0;
            e_fault_rail = '0;
            e_all_pg     = 1'b0;
            e_pwr_fault  = 1'b0;
            e_req        = 1'b0;
            e_code       = 2'b00;
        end else begin
            cyc++;
            m_any_flt = 1'b0;
            m_all_on  = 1'b1;
            m_enter   = '0;
            for (int i = 0; i < NR; i++) begin
                m_code[i] = 0;
                m_nx[i]   = m_st[i];
                if (m_st[i] == R_FLT) m_any_flt = 1'b1;
                if (m_st[i] != R_ON)  m_all_on  = 1'b0;
                case (m_st[i])
                    R_OFF: if (rail_en[i]) m_nx[i] = R_UP;
                    R_UP: begin
                        if (e_pg_db[i])                   m_nx[i] = R_ON;
                        else if (!rail_en[i])             m_nx[i] = R_DN;
                        else if (cyc - m_entry[i] == PT) begin
                            m_nx[i] = R_FLT; m_code[i] = 1;
                        end
                    end
                    R_ON: begin
                        if (!rail_en[i])     m_nx[i] = R_DN;
                        else if (!e_pg_db[i]) begin
                            m_nx[i] = R_FLT; m_code[i] = 2;
                        end
                    end
                    R_DN: begin
                        if (!e_pg_db[i])                  m_nx[i] = R_OFF;
                        else if (rail_en[i])              m_nx[i] = R_UP;
                        else if (cyc - m_entry[i] == PT) begin
                            m_nx[i] = R_FLT; m_code[i] = 3;
                        end
                    end
                    default: if (fault_clr && !rail_en[i]) m_nx[i] = R_OFF;
                endcase
                if (m_nx[i] == R_FLT && m_st[i] != R_FLT) m_enter[i] = 1'b1;
            end
            if (!m_any_flt) begin
                if (m_enter != '0) begin
                    e_fault_rail = m_enter;
                    e_req        = 1'b1;
                    for (int i = 0; i < NR; i++) begin
                        if (m_enter[i]) begin
                            e_code = 2'(m_code[i]);
                            break;
                        end
                    end
                end else begin
                    e_fault_rail = '0;
                    e_req        = 1'b0;
                    e_code       = 2'b00;
                end
            end
            e_all_pg    = m_all_on;
            e_pwr_fault = m_any_flt;
            for (int i = 0; i < NR; i++) begin
                m_hist[i] = {m_hist[i][14:0], pg_in[i]};
                m_flip = 1'b1;
                for (int k = 2; k < DG + 2; k++) begin
                    if (m_hist[i][k] == e_pg_db[i]) m_flip = 1'b0;
                end
                if (m_flip) e_pg_db[i] = ~e_pg_db[i];
                if (m_nx[i] != m_st[i]) m_entry[i] = cyc;
                m_st[i] = m_nx[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("pg_db",       32'(pg_db),       32'(e_pg_db));
        chk("all_pg",      32'(all_pg),      32'(e_all_pg));
        chk("pwr_fault",   32'(pwr_fault),   32'(e_pwr_fault));
        chk("fault_rail",  32'(fault_rail),  32'(e_fault_rail));
        chk("fault_code",  32'(fault_code),  32'(e_code));
        chk("req_pwr_off", 32'(req_pwr_off), 32'(e_req));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge fsm_clk);
            cmp_all();
        end
    endtask

    task automatic bring_up(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) begin
                rail_en[i] = 1'b1;
                step(3);
                pg_in[i] = 1'b1;
            end
        end
        step(12);
    endtask

    task automatic shutdown();
        rail_en = '0;
        pg_in   = '0;
        step(2);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        step(12);
        chk("idle_pwr_fault", 32'(pwr_fault), 32'd0);
        chk("idle_req",       32'(req_pwr_off), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge fsm_clk);
        chk("rst_pg_db",      32'(pg_db),       32'd0);
        chk("rst_all_pg",     32'(all_pg),      32'd0);
        chk("rst_pwr_fault",  32'(pwr_fault),   32'd0);
        chk("rst_fault_rail", 32'(fault_rail),  32'd0);
        chk("rst_fault_code", 32'(fault_code),  32'd0);
        chk("rst_req",        32'(req_pwr_off), 32'd0);
        reset_n = 1'b1;
        step(2);

        // Normal ramp of all rails
        bring_up(6'b111111);
        chk("ramp_all_pg",    32'(all_pg),    32'd1);
        chk("ramp_pwr_fault", 32'(pwr_fault), 32'd0);
        chk("ramp_pg_db",     32'(pg_db),     32'h3f);

        // Short glitch is filtered, long drop faults
        pg_in[0] = 1'b0;
        step(3);
        pg_in[0] = 1'b1;
        step(10);
        chk("glitch_pwr_fault", 32'(pwr_fault), 32'd0);
        chk("glitch_pg_db",     32'(pg_db),     32'h3f);
        pg_in[0] = 1'b0;
        step(6);
        pg_in[0] = 1'b1;
        step(4);
        chk("drop_pwr_fault",  32'(pwr_fault),   32'd1);
        chk("drop_fault_code", 32'(fault_code),  32'd2);
        chk("drop_fault_rail", 32'(fault_rail),  32'h01);
        chk("drop_req",        32'(req_pwr_off), 32'd1);
        shutdown();

        // Rise timeout on rail 2, checked on both sides of the boundary
        rail_en[2] = 1'b1;
        step(17);
        chk("rise_early_pwr_fault", 32'(pwr_fault), 32'd0);
        step(1);
        chk("rise_pwr_fault",  32'(pwr_fault),   32'd1);
        chk("rise_fault_rail", 32'(fault_rail),  32'h04);
        chk("rise_fault_code", 32'(fault_code),  32'd1);
        chk("rise_req",        32'(req_pwr_off), 32'd1);
        shutdown();

        // Stuck-on rail 3
        bring_up(6'b001000);
        rail_en[3] = 1'b0;
        step(17);
        chk("stuck_early_pwr_fault", 32'(pwr_fault), 32'd0);
        step(1);
        chk("stuck_pwr_fault",  32'(pwr_fault),  32'd1);
        chk("stuck_fault_code", 32'(fault_code), 32'd3);
        chk("stuck_fault_rail", 32'(fault_rail), 32'h08);
        shutdown();

        // Simultaneous dropouts, blocked clear, then effective clear
        bring_up(6'b010010);
        pg_in[1] = 1'b0;
        pg_in[4] = 1'b0;
        step(10);
        chk("simul_fault_rail", 32'(fault_rail), 32'h12);
        chk("simul_fault_code", 32'(fault_code), 32'd2);
        chk("simul_pwr_fault",  32'(pwr_fault),  32'd1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        step(3);
        chk("hold_fault_rail", 32'(fault_rail),  32'h12);
        chk("hold_pwr_fault",  32'(pwr_fault),   32'd1);
        chk("hold_req",        32'(req_pwr_off), 32'd1);
        rail_en = '0;
        step(1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        step(1);
        chk("clr_pwr_fault",  32'(pwr_fault),   32'd0);
        chk("clr_req",        32'(req_pwr_off), 32'd0);
        chk("clr_fault_rail", 32'(fault_rail),  32'd0);
        shutdown();

        // Asynchronous reset during rail 5 ramp-up
        bring_up(6'b011111);
        rail_en[5] = 1'b1;
        step(4);
        chk("pre_rst_pg_db", 32'(pg_db), 32'h1f);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_pg_db",      32'(pg_db),       32'd0);
        chk("async_all_pg",     32'(all_pg),      32'd0);
        chk("async_pwr_fault",  32'(pwr_fault),   32'd0);
        chk("async_fault_rail", 32'(fault_rail),  32'd0);
        chk("async_fault_code", 32'(fault_code),  32'd0);
        chk("async_req",        32'(req_pwr_off), 32'd0);
        rail_en = '0;
        pg_in   = '0;
        step(2);
        reset_n = 1'b1;
        step(30);
        chk("post_rst_pwr_fault", 32'(pwr_fault), 32'd0);
        chk("post_rst_all_pg",    32'(all_pg),    32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 15) == 0) rail_en[i] = ~rail_en[i];
                if ($urandom_range(0, 3) == 0)       pg_in[i] = rail_en[i];
                else if ($urandom_range(0, 40) == 0) pg_in[i] = ~pg_in[i];
            end
            fault_clr = ($urandom_range(0, 19) == 0);
            step(1);
        end
        fault_clr = 1'b0;
        shutdown();
        shutdown();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
